// File: rtl/mod107_residue_accumulator.sv
// Mod-107 residue accumulator: sums per-chunk LUT residues of a 400-bit
// operand and presents the frame residue with a count/range error flag.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   residue beat handshake (in_res, in_last)
//   out_valid/out_ready frame result handshake (out_res, out_err)
module mod107_residue_accumulator #(
    parameter int MOD        = 107,
    parameter int RES_W      = 7,
    parameter int NUM_CHUNKS = 67,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_res,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic             out_err
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam logic [RES_W:0] MOD_X =
        (RES_W+1)'(MOD);
    localparam logic [CNT_W:0] NUM_X =
        (CNT_W+1)'(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0] CNT_ONE =
        (CNT_W+1)'(1);

    state_t             state;
    logic [RES_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               err_sticky;

    logic               beat;
    logic               in_oor;
    logic [RES_W:0]     in_x;
    logic [RES_W-1:0]   r;
    logic [RES_W:0]     s;
    logic [RES_W-1:0]   acc_next;
    logic [CNT_W:0]     cnt_inc;
    logic [CNT_W-1:0]   cnt_next;
    logic               count_bad;
    logic               err_next;

    assign beat   = in_valid & in_ready;

    // Residues >= MOD are folded once; a 7-bit value
    // is always < 2*MOD so one subtract suffices.
    assign in_x   = {1'b0, in_res};
    assign in_oor = in_x >= MOD_X;
    assign r      = in_oor ? RES_W'(in_x - MOD_X)
                           : in_res;

    // Both operands < MOD, so the sum fits in
    // RES_W+1 bits and needs one conditional subtract.
    assign s        = {1'b0, acc} + {1'b0, r};
    assign acc_next = (s >= MOD_X) ? RES_W'(s - MOD_X)
                                   : s[RES_W-1:0];

    // Count compare is done one bit wider so a
    // saturated counter can never alias NUM_CHUNKS.
    assign cnt_inc   = {1'b0, cnt} + CNT_ONE;
    assign cnt_next  = (cnt == CNT_MAX) ? cnt
                                        : cnt_inc[CNT_W-1:0];
    assign count_bad = cnt_inc != NUM_X;
    assign err_next  = err_sticky | in_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            err_sticky <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_err    <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        acc        <= acc_next;
                        cnt        <= cnt_next;
                        err_sticky <= err_next;
                        if (in_last) begin
                            out_res   <= acc_next;
                            out_err   <= err_next | count_bad;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        acc        <= '0;
                        cnt        <= '0;
                        err_sticky <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod107_residue_accumulator.sv
// Scoreboard bench for mod107_residue_accumulator: expected frame
// results are queued at stimulus time and compared at output handshake.
module tb_mod107_residue_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_res;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_res;
    logic       out_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    mod107_residue_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input int got,
                         input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d",
                     tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("out_res", int'(out_res), int'(e[6:0]));
                check("out_err", int'(out_err), int'(e[7]));
            end
        end
    end

    // Present one beat and hold it until accepted.
    task automatic drive_beat(input int v,
                              input bit last);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_res   = 7'(v);
        in_last  = last;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int vals[$]);
        int n;
        int sum;
        bit e;
        n   = vals.size();
        sum = 0;
        e   = (n != 67);
        foreach (vals[i]) begin
            int v;
            v = vals[i];
            if (v >= 107) begin
                v -= 107;
                e = 1'b1;
            end
            sum += v;
        end
        exp_q.push_back({e, 7'(sum % 107)});
        for (int i = 0; i < n; i++)
            drive_beat(vals[i], i == n - 1);
        @(negedge clk);
        check("latency_valid", int'(out_valid), 1);
    endtask

    task automatic wait_results;
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0)
            check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        check("ready_after", int'(in_ready), 1);
        check("valid_after", int'(out_valid), 0);
    endtask

    function automatic void fill(output int q[$],
                                 input int n,
                                 input int v);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(v);
    endfunction

    initial begin
        int fr[$];
        logic [6:0] hres;
        logic       herr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_res    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_res", int'(out_res), 0);
        check("rst_err", int'(out_err), 0);
        check("rst_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("rel_ready0", int'(in_ready), 0);
        @(negedge clk);
        check("rel_ready1", int'(in_ready), 1);

        fill(fr, 67, 106);
        send_frame(fr);
        wait_results();

        fill(fr, 67, 0);
        send_frame(fr);
        wait_results();

        fill(fr, 67, 1);
        send_frame(fr);
        wait_results();

        fr = '{100, 10};
        send_frame(fr);
        wait_results();

        fr = '{5};
        send_frame(fr);
        wait_results();

        // Out-of-range first beat with stalled consumer.
        out_ready = 1'b0;
        fill(fr, 67, 0);
        fr[0] = 120;
        send_frame(fr);
        hres = out_res;
        herr = out_err;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_res   = 7'd50;
            in_last  = 1'b1;
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_ready", int'(in_ready), 0);
            check("hold_res", int'(out_res), int'(hres));
            check("hold_err", int'(out_err), int'(herr));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_results();

        // Abort a frame with reset mid-stream.
        for (int i = 0; i < 30; i++) drive_beat(3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill(fr, 67, 2);
        send_frame(fr);
        wait_results();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
